// File: rtl/clk_reset_seq.sv
// clk_reset_seq: clock bring-up sequencer for a bank of three DCMs.
// Pulses the DCM reset and waits for all three lock flags. The locks must then
// stay high for a settle window before downstream reset is released. A failed
// attempt is retried until the retry budget is spent. A lock loss while running
// triggers a new bring-up.
//
// Ports
//   CLOCK_13   in   free-running 13 MHz clock (only clock)
//   RST_N      in   asynchronous active-low reset
//   LOCKED_IN  in   [2:0] per-DCM lock flags, asynchronous to CLOCK_13
//   RESTART    in   synchronous restart request, level-sampled
//   DCM_RST    out  reset to all DCMs, active high
//   SYS_RST_N  out  active-low reset to downstream logic
//   READY      out  clocks stable
//   FAULT      out  retry budget exhausted
//   RETRY_CNT  out  [3:0] failed attempts since last RUN entry or RESTART
//   LOSS_CNT   out  [7:0] lock losses seen in RUN, saturating
//   STATE      out  [2:0] encoded FSM state
`timescale 1ns/1ps
module clk_reset_seq #(
  parameter int unsigned RST_CYCLES    = 8,
  parameter int unsigned LOCK_TIMEOUT  = 65535,
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 7
) (
  input  logic       CLOCK_13,
  input  logic       RST_N,
  input  logic [2:0] LOCKED_IN,
  input  logic       RESTART,
  output logic       DCM_RST,
  output logic       SYS_RST_N,
  output logic       READY,
  output logic       FAULT,
  output logic [3:0] RETRY_CNT,
  output logic [7:0] LOSS_CNT,
  output logic [2:0] STATE
);

  localparam logic [2:0] StResetHold = 3'd0;
  localparam logic [2:0] StWaitLock  = 3'd1;
  localparam logic [2:0] StSettle    = 3'd2;
  localparam logic [2:0] StRun       = 3'd3;
  localparam logic [2:0] StFault     = 3'd4;

  // Terminal values of the shared cycle counter for each timed state.
  localparam logic [15:0] RstLast     = 16'(RST_CYCLES - 1);
  localparam logic [15:0] TimeoutLast = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] SettleLast  = 16'(SETTLE_CYCLES - 1);
  localparam logic [3:0]  RetryMax    = 4'(MAX_RETRIES);

  logic [2:0]  lock_meta_q, lock_sync_q;
  logic        locked;
  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  retry_q, retry_d, retry_inc;
  logic [7:0]  loss_q, loss_d;
  logic        dcm_rst_q, dcm_rst_d;
  logic        sys_rst_n_q, sys_rst_n_d;
  logic        ready_q, ready_d;
  logic        fault_q, fault_d;
  logic        attempt_failed;

  assign locked    = &lock_sync_q;
  assign retry_inc = retry_q + 4'd1;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    retry_d        = retry_q;
    loss_d         = loss_q;
    dcm_rst_d      = dcm_rst_q;
    sys_rst_n_d    = sys_rst_n_q;
    ready_d        = ready_q;
    fault_d        = fault_q;
    attempt_failed = 1'b0;

    case (state_q)
      StResetHold: begin
        dcm_rst_d   = 1'b1;
        sys_rst_n_d = 1'b0;
        ready_d     = 1'b0;
        fault_d     = 1'b0;
        if (cnt_q == RstLast) begin
          state_d   = StWaitLock;
          cnt_d     = '0;
          dcm_rst_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StWaitLock: begin
        dcm_rst_d = 1'b0;
        // Lock wins over a timeout landing on the same cycle.
        if (locked) begin
          state_d = StSettle;
          cnt_d   = '0;
        end else if (cnt_q == TimeoutLast) begin
          attempt_failed = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StSettle: begin
        if (!locked) begin
          attempt_failed = 1'b1;
        end else if (cnt_q == SettleLast) begin
          state_d     = StRun;
          cnt_d       = '0;
          sys_rst_n_d = 1'b1;
          ready_d     = 1'b1;
          retry_d     = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StRun: begin
        if (!locked) begin
          state_d     = StResetHold;
          cnt_d       = '0;
          dcm_rst_d   = 1'b1;
          sys_rst_n_d = 1'b0;
          ready_d     = 1'b0;
          loss_d      = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
        end
      end
      StFault: begin
        fault_d     = 1'b1;
        dcm_rst_d   = 1'b0;
        sys_rst_n_d = 1'b0;
        ready_d     = 1'b0;
      end
      default: begin
        // Unused encodings recover through a full reset pulse.
        state_d     = StResetHold;
        cnt_d       = '0;
        dcm_rst_d   = 1'b1;
        sys_rst_n_d = 1'b0;
        ready_d     = 1'b0;
        fault_d     = 1'b0;
      end
    endcase

    if (attempt_failed) begin
      retry_d = retry_inc;
      cnt_d   = '0;
      if (retry_inc == RetryMax) begin
        state_d   = StFault;
        fault_d   = 1'b1;
        dcm_rst_d = 1'b0;
      end else begin
        state_d   = StResetHold;
        dcm_rst_d = 1'b1;
      end
    end

    // Restart overrides everything except the loss history.
    if (RESTART) begin
      state_d     = StResetHold;
      cnt_d       = '0;
      retry_d     = '0;
      fault_d     = 1'b0;
      dcm_rst_d   = 1'b1;
      sys_rst_n_d = 1'b0;
      ready_d     = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_13 or negedge RST_N) begin
    if (!RST_N) begin
      lock_meta_q <= '0;
      lock_sync_q <= '0;
      state_q     <= StResetHold;
      cnt_q       <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      dcm_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      lock_meta_q <= LOCKED_IN;
      lock_sync_q <= lock_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      dcm_rst_q   <= dcm_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
    end
  end

  assign DCM_RST   = dcm_rst_q;
  assign SYS_RST_N = sys_rst_n_q;
  assign READY     = ready_q;
  assign FAULT     = fault_q;
  assign RETRY_CNT = retry_q;
  assign LOSS_CNT  = loss_q;
  assign STATE     = state_q;

endmodule

// File: tb/tb_clk_reset_seq.sv
// tb_clk_reset_seq: self-checking bench for clk_reset_seq.
// Expected output values are queued with the cycle they are due on and
// compared at the falling edge of that cycle.
`timescale 1ns/1ps
module tb_clk_reset_seq;

  localparam int SState = 0, SDcm = 1, SSys = 2, SRdy = 3, SFlt = 4, SRetry = 5, SLoss = 6;

  logic       CLOCK_13 = 1'b0;
  logic       RST_N = 1'b0;
  logic [2:0] LOCKED_IN = 3'b000;
  logic       RESTART = 1'b0;
  logic       DCM_RST, SYS_RST_N, READY, FAULT;
  logic [3:0] RETRY_CNT;
  logic [7:0] LOSS_CNT;
  logic [2:0] STATE;

  clk_reset_seq #(
    .RST_CYCLES   (8),
    .LOCK_TIMEOUT (100),
    .SETTLE_CYCLES(16),
    .MAX_RETRIES  (3)
  ) dut (
    .CLOCK_13 (CLOCK_13),
    .RST_N    (RST_N),
    .LOCKED_IN(LOCKED_IN),
    .RESTART  (RESTART),
    .DCM_RST  (DCM_RST),
    .SYS_RST_N(SYS_RST_N),
    .READY    (READY),
    .FAULT    (FAULT),
    .RETRY_CNT(RETRY_CNT),
    .LOSS_CNT (LOSS_CNT),
    .STATE    (STATE)
  );

  always #5 CLOCK_13 = ~CLOCK_13;

  typedef struct {
    string       tag;
    int unsigned due;
    int          sel;
    int unsigned val;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always @(posedge CLOCK_13) cyc <= cyc + 1;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int unsigned obs(input int sel);
    case (sel)
      SState:  return int'(STATE);
      SDcm:    return int'(DCM_RST);
      SSys:    return int'(SYS_RST_N);
      SRdy:    return int'(READY);
      SFlt:    return int'(FAULT);
      SRetry:  return int'(RETRY_CNT);
      default: return int'(LOSS_CNT);
    endcase
  endfunction

  task automatic expect_at(input string tag, input int unsigned dt, input int sel,
                           input int unsigned val);
    exp_t e;
    e.tag = tag;
    e.due = cyc + dt;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  // Scoreboard drain: compare every entry due on this cycle.
  always @(negedge CLOCK_13) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        check(sb[i].tag, obs(sb[i].sel), sb[i].val);
        sb.delete(i);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK_13);
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_state"}, obs(SState), 0);
    check({pfx, "_dcm"},   obs(SDcm),   1);
    check({pfx, "_sys"},   obs(SSys),   0);
    check({pfx, "_ready"}, obs(SRdy),   0);
    check({pfx, "_fault"}, obs(SFlt),   0);
    check({pfx, "_retry"}, obs(SRetry), 0);
    check({pfx, "_loss"},  obs(SLoss),  0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int width;

    // Reset state
    tick(3);
    check_reset_vals("rst");

    // Nominal bring-up
    RST_N = 1'b1;
    expect_at("up_hold_dcm", 7, SDcm, 1);
    expect_at("up_hold_st",  7, SState, 0);
    expect_at("up_dcm_fall", 8, SDcm, 0);
    expect_at("up_wait_st",  8, SState, 1);
    tick(28);
    LOCKED_IN = 3'b111;
    expect_at("up_sync_lat",   2, SState, 1);
    expect_at("up_settle",     3, SState, 2);
    expect_at("up_settle_end", 18, SState, 2);
    expect_at("up_pre_ready",  18, SRdy, 0);
    expect_at("up_run",        19, SState, 3);
    expect_at("up_ready",      19, SRdy, 1);
    expect_at("up_sysrst",     19, SSys, 1);
    expect_at("up_retry",      19, SRetry, 0);
    tick(22);

    // One-cycle lock loss in RUN
    LOCKED_IN = 3'b101;
    expect_at("loss_sys_hold", 2, SSys, 1);
    expect_at("loss_sys",      3, SSys, 0);
    expect_at("loss_ready",    3, SRdy, 0);
    expect_at("loss_cnt",      3, SLoss, 1);
    expect_at("loss_hold_st",  3, SState, 0);
    expect_at("loss_dcm",      3, SDcm, 1);
    expect_at("loss_dcm_last", 10, SDcm, 1);
    expect_at("loss_dcm_fall", 11, SDcm, 0);
    expect_at("loss_settle",   12, SState, 2);
    expect_at("loss_rerun",    28, SState, 3);
    expect_at("loss_reready",  28, SRdy, 1);
    expect_at("loss_keep",     28, SLoss, 1);
    tick(1);
    LOCKED_IN = 3'b111;
    tick(31);

    // Restart from RUN, then a lock glitch mid-settle
    RESTART = 1'b1;
    expect_at("rs_run_st",    1, SState, 0);
    expect_at("rs_run_retry", 1, SRetry, 0);
    expect_at("rs_run_fault", 1, SFlt, 0);
    expect_at("rs_run_loss",  1, SLoss, 1);
    expect_at("rs_run_sys",   1, SSys, 0);
    expect_at("gl_settle",    10, SState, 2);
    expect_at("gl_pre_drop",  19, SState, 2);
    expect_at("gl_hold",      20, SState, 0);
    expect_at("gl_retry",     20, SRetry, 1);
    expect_at("gl_dcm",       20, SDcm, 1);
    expect_at("gl_retry_kept", 44, SRetry, 1);
    for (int k = 1; k <= 44; k++) expect_at("gl_no_ready", k, SRdy, 0);
    expect_at("gl_run",       45, SState, 3);
    expect_at("gl_retry_clr", 45, SRetry, 0);
    tick(1);
    RESTART = 1'b0;
    tick(16);
    LOCKED_IN = 3'b110;
    tick(1);
    LOCKED_IN = 3'b111;
    tick(30);

    // Timeout path to FAULT
    RESTART   = 1'b1;
    LOCKED_IN = 3'b011;
    tick(1);
    RESTART = 1'b0;
    pulses  = 0;
    width   = 1;
    for (int k = 0; k < 1000 && !FAULT; k++) begin
      @(negedge CLOCK_13);
      if (DCM_RST) begin
        width++;
      end else if (width != 0) begin
        check("to_pulse_width", width, 8);
        pulses++;
        width = 0;
      end
    end
    check("to_pulses", pulses, 3);
    check("to_fault",  obs(SFlt), 1);
    check("to_retry",  obs(SRetry), 3);
    check("to_state",  obs(SState), 4);
    check("to_sys",    obs(SSys), 0);
    check("to_ready",  obs(SRdy), 0);
    tick(5);
    check("to_fault_held", obs(SState), 4);
    check("to_dcm_low",    obs(SDcm), 0);

    // Restart from FAULT
    RESTART   = 1'b1;
    LOCKED_IN = 3'b111;
    expect_at("rs_flt_st",    1, SState, 0);
    expect_at("rs_flt_fault", 1, SFlt, 0);
    expect_at("rs_flt_retry", 1, SRetry, 0);
    expect_at("rs_flt_loss",  1, SLoss, 1);
    expect_at("rs_flt_dcm",   1, SDcm, 1);
    expect_at("rs_flt_wait",  9, SState, 1);
    expect_at("rs_flt_settle", 10, SState, 2);
    expect_at("rs_flt_run",   26, SState, 3);
    expect_at("rs_flt_ready", 26, SRdy, 1);
    tick(1);
    RESTART = 1'b0;
    tick(29);

    // Asynchronous reset in the middle of WAIT_LOCK
    RESTART   = 1'b1;
    LOCKED_IN = 3'b000;
    tick(1);
    RESTART = 1'b0;
    tick(11);
    check("ar_in_wait", obs(SState), 1);
    check("ar_pre_loss", obs(SLoss), 1);
    #2;
    RST_N = 1'b0;
    #1;
    check_reset_vals("ar");
    @(negedge CLOCK_13);
    RST_N = 1'b1;
    expect_at("ar_hold_dcm", 7, SDcm, 1);
    expect_at("ar_dcm_fall", 8, SDcm, 0);
    expect_at("ar_wait_st",  8, SState, 1);
    tick(10);

    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
